data_memory: RTL and testbench

Word-organised data memory directly downstream of the ALU in the single-cycle datapath: the ALU result is the byte address, the second register operand is the store data. It supports byte, halfword and word loads and stores with sign/zero extension and flags misaligned accesses. After reset a clear state machine zeroes every word and holds `busy` high so the control unit can stall the PC.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/data_memory_if.sv | 24 ++
 rtl/mem_load_align.sv | 35 +++
 rtl/data_memory.sv | 99 +++++++++
 tb/tb_data_memory.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory: access sizes, clear FSM states, word width.
package dmem_pkg;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_e;
endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
interface data_memory_if;
  import dmem_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [DATA_W-1:0] rdata;
  logic              misaligned;
  logic              busy;

  modport master (
    output addr, wdata, mem_read, mem_write, size, unsigned_ld,
    input  rdata, misaligned, busy
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write, size, unsigned_ld,
    output rdata, misaligned, busy
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half/word out of a memory word, extends it, and
// reports the raw alignment violation for the requested size.
module mem_load_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data     = '0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: begin
        o_misalign = i_lane[0];
        o_data     = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      // reserved encoding behaves as a word access
      default: begin
        o_misalign = (i_lane != 2'b00);
        o_data     = i_word;
      end
    endcase
  end
endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte/half/word access and a post-reset
// clear sweep that holds busy high until every word has been zeroed.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  data_memory_if.slave   bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  dm_state_e         r_state, w_state_nxt;
  logic [AW-1:0]     r_clr_ptr, w_clr_ptr_nxt;

  logic [AW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_mis_raw;
  logic              w_busy;
  logic              w_we;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wd;
  logic              w_unused;

  assign w_idx    = bus.addr[AW+1:2];
  assign w_lane   = bus.addr[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_busy   = (r_state == DM_CLEAR);
  assign w_unused = ^bus.addr[DATA_W-1:AW+2];

  mem_load_align u_align (
    .i_word     (w_word),
    .i_lane     (w_lane),
    .i_size     (bus.size),
    .i_unsigned (bus.unsigned_ld),
    .o_data     (w_ld_data),
    .o_misalign (w_mis_raw)
  );

  assign bus.busy       = w_busy;
  assign bus.misaligned = (bus.mem_read | bus.mem_write) & w_mis_raw;
  assign bus.rdata      = (bus.mem_read && !w_busy && !w_mis_raw) ? w_ld_data : '0;

  // Store data is replicated across lanes so each lane just picks its own slice.
  always_comb begin
    w_be = 4'b0000;
    w_wd = bus.wdata;
    case (bus.size)
      SZ_BYTE: begin
        w_be[w_lane] = 1'b1;
        w_wd         = {4{bus.wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{bus.wdata[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  assign w_we = i_rst_n & bus.mem_write & ~w_busy & ~w_mis_raw;

  // No reset on the array: the reset edge itself leaves contents alone.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_state == DM_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_we) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wd[8*l +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= DM_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      DM_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == AW'(DEPTH_WORDS - 1)) w_state_nxt = DM_READY;
      end
      default: w_state_nxt = DM_READY;
    endcase
  end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: clear sweep timing, lane loads/stores,
// misalignment, address wrap and reset during an active sweep.
module tb_data_memory;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic [31:0] addr, logic [1:0] size, logic uns,
                              logic re, logic we, logic [31:0] wdata,
                              logic [31:0] exp_rd, logic exp_mis);
    vec_t v;
    v.name = name; v.addr = addr; v.size = size; v.uns = uns; v.re = re; v.we = we;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.addr = '0; bus.wdata = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.size = SZ_WORD; bus.unsigned_ld = 1'b0;
  endtask

  // Drive one access for one cycle; expectations go through the scoreboard.
  task automatic apply(vec_t v);
    vec_t e;
    bus.addr = v.addr; bus.size = v.size; bus.unsigned_ld = v.uns;
    bus.mem_read = v.re; bus.mem_write = v.we; bus.wdata = v.wdata;
    sb.push_back(v);
    #4;
    e = sb.pop_front();
    chk({e.name, ".rdata"}, bus.rdata, e.exp_rd);
    chk({e.name, ".mis"}, {31'h0, bus.misaligned}, {31'h0, e.exp_mis});
    tick();
    idle();
  endtask

  // Counts edges after release until busy drops; optional dropped store at edge st_at.
  task automatic count_busy(string name, int st_at);
    int cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2*DEPTH) begin
      if (cnt == st_at - 1) begin
        bus.addr = 32'h14; bus.wdata = 32'h7777_7777; bus.size = SZ_WORD;
        bus.mem_write = 1'b1; bus.mem_read = 1'b1;
        #4;
        chk({name, ".rd_busy"}, bus.rdata, 32'h0);
      end
      tick();
      idle();
      cnt++;
    end
    chk({name, ".busy_cycles"}, cnt, DEPTH);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.busy", {31'h0, bus.busy}, 32'h1);
    chk("rst.rdata", bus.rdata, 32'h0);
    chk("rst.mis", {31'h0, bus.misaligned}, 32'h0);

    // Load of 0x0 while the sweep is about to start
    rst_n = 1'b1;
    bus.mem_read = 1'b1; bus.addr = 32'h0;
    #4;
    chk("busy_load0", bus.rdata, 32'h0);
    idle();
    count_busy("sweep1", -10);
    chk("ready.busy", {31'h0, bus.busy}, 32'h0);

    for (int i = 0; i < DEPTH; i++)
      apply(mk($sformatf("zero[%0d]", i), 32'(4*i), SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0));

    vecs.push_back(mk("st_w10",    32'h10, SZ_WORD, 0, 0, 1, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk("lb10",      32'h10, SZ_BYTE, 0, 1, 0, 0, 32'hFFFFFFEF, 0));
    vecs.push_back(mk("lb11",      32'h11, SZ_BYTE, 0, 1, 0, 0, 32'hFFFFFFBE, 0));
    vecs.push_back(mk("lb12",      32'h12, SZ_BYTE, 0, 1, 0, 0, 32'hFFFFFFAD, 0));
    vecs.push_back(mk("lb13",      32'h13, SZ_BYTE, 0, 1, 0, 0, 32'hFFFFFFDE, 0));
    vecs.push_back(mk("lbu10",     32'h10, SZ_BYTE, 1, 1, 0, 0, 32'h000000EF, 0));
    vecs.push_back(mk("lbu11",     32'h11, SZ_BYTE, 1, 1, 0, 0, 32'h000000BE, 0));
    vecs.push_back(mk("lbu12",     32'h12, SZ_BYTE, 1, 1, 0, 0, 32'h000000AD, 0));
    vecs.push_back(mk("lbu13",     32'h13, SZ_BYTE, 1, 1, 0, 0, 32'h000000DE, 0));
    vecs.push_back(mk("lh10",      32'h10, SZ_HALF, 0, 1, 0, 0, 32'hFFFFBEEF, 0));
    vecs.push_back(mk("st_b12",    32'h12, SZ_BYTE, 0, 0, 1, 32'hFFFFFF5A, 32'h0, 0));
    vecs.push_back(mk("lw10",      32'h10, SZ_WORD, 0, 1, 0, 0, 32'hDE5ABEEF, 0));
    vecs.push_back(mk("lh12",      32'h12, SZ_HALF, 0, 1, 0, 0, 32'hFFFFDE5A, 0));
    vecs.push_back(mk("lhu12",     32'h12, SZ_HALF, 1, 1, 0, 0, 32'h0000DE5A, 0));
    vecs.push_back(mk("lh11_mis",  32'h11, SZ_HALF, 0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk("st_w21",    32'h21, SZ_WORD, 0, 0, 1, 32'hAAAA5555, 32'h0, 1));
    vecs.push_back(mk("st_h23",    32'h23, SZ_HALF, 0, 0, 1, 32'h0000BBBB, 32'h0, 1));
    vecs.push_back(mk("lw20",      32'h20, SZ_WORD, 0, 1, 0, 0, 32'h0, 0));
    vecs.push_back(mk("lw22_mis",  32'h22, SZ_WORD, 0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk("noacc_mis", 32'h23, SZ_WORD, 0, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk("rsv10",     32'h10, 2'b11,   0, 1, 0, 0, 32'hDE5ABEEF, 0));
    vecs.push_back(mk("rsv12_mis", 32'h12, 2'b11,   0, 1, 0, 0, 32'h0, 1));
    vecs.push_back(mk("st_h22",    32'h22, SZ_HALF, 0, 0, 1, 32'h99991234, 32'h0, 0));
    vecs.push_back(mk("lw20_h",    32'h20, SZ_WORD, 0, 1, 0, 0, 32'h12340000, 0));
    vecs.push_back(mk("st_w400",   32'h400, SZ_WORD, 0, 0, 1, 32'h12345678, 32'h0, 0));
    vecs.push_back(mk("lw0_wrap",  32'h0, SZ_WORD, 0, 1, 0, 0, 32'h12345678, 0));
    vecs.push_back(mk("lw_hiaddr", 32'hFFFF0010, SZ_WORD, 0, 1, 0, 0, 32'hDE5ABEEF, 0));
    vecs.push_back(mk("rw_same",   32'h0, SZ_WORD, 0, 1, 1, 32'hCAFEF00D, 32'h12345678, 0));
    vecs.push_back(mk("lw0_after", 32'h0, SZ_WORD, 0, 1, 0, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk("lw14_pre",  32'h14, SZ_WORD, 0, 1, 0, 0, 32'h0, 0));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset pulse in the middle of a sweep restarts it from word 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("mid.busy100", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy("sweep2", 200);
    apply(mk("drop_st14", 32'h14, SZ_WORD, 0, 1, 0, 0, 32'h0, 0));
    apply(mk("lw10_clr",  32'h10, SZ_WORD, 0, 1, 0, 0, 32'h0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
